// File: rtl/fetch_unit.sv
// Decoupled instruction-fetch front end: owns the fetch PC, issues imem word requests,
// buffers in-order responses and hands {instr, pc, pc+4} to decode.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            rsp_valid,
  input  logic [XLEN-1:0] rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc4,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            misaligned
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int DW = PW + 4;

  logic [XLEN-1:0] fetch_pc;
  logic [PW-1:0]   alloc_ptr, fill_ptr, read_ptr;
  logic [DW-1:0]   drop_cnt;
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];

  logic [PW-1:0] occupancy, outstanding;
  logic          req_fire, dec_fire, rsp_drop, rsp_fill;
  logic [DW-1:0] drop_total, drop_redirect;
  logic          unused_pc_bit0;

  assign unused_pc_bit0 = redirect_pc[0];

  assign occupancy   = alloc_ptr - read_ptr;
  assign outstanding = alloc_ptr - fill_ptr;

  // Outputs are gated by reset so they drop the instant reset asserts.
  assign req_valid   = reset && (occupancy < PW'(DEPTH)) && !redirect_valid;
  assign req_addr    = fetch_pc;
  assign instr_valid = reset && (read_ptr != fill_ptr) && !redirect_valid;

  assign req_fire = req_valid && req_ready;
  assign dec_fire = instr_valid && instr_ready;

  // Responses belonging to requests issued before a redirect are counted off by drop_cnt.
  assign rsp_drop = rsp_valid && (drop_cnt != '0);
  assign rsp_fill = rsp_valid && (drop_cnt == '0) && (outstanding != '0) && !redirect_valid;

  assign drop_total    = drop_cnt + DW'(outstanding);
  assign drop_redirect = (rsp_valid && (drop_total != '0)) ? drop_total - DW'(1) : drop_total;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc   <= RESET_PC;
      alloc_ptr  <= '0;
      fill_ptr   <= '0;
      read_ptr   <= '0;
      drop_cnt   <= '0;
      misaligned <= 1'b0;
    end else begin
      misaligned <= redirect_valid && redirect_pc[1];
      if (redirect_valid) begin
        fetch_pc  <= {redirect_pc[XLEN-1:2], 2'b00};
        alloc_ptr <= '0;
        fill_ptr  <= '0;
        read_ptr  <= '0;
        drop_cnt  <= drop_redirect;
      end else begin
        if (req_fire) begin
          fetch_pc  <= fetch_pc + XLEN'(4);
          alloc_ptr <= alloc_ptr + PW'(1);
        end
        if (rsp_drop) drop_cnt <= drop_cnt - DW'(1);
        if (rsp_fill) fill_ptr <= fill_ptr + PW'(1);
        if (dec_fire) read_ptr <= read_ptr + PW'(1);
      end
    end
  end

  // Entry storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (req_fire) pc_mem[alloc_ptr[AW-1:0]] <= fetch_pc;
    if (rsp_fill) instr_mem[fill_ptr[AW-1:0]] <= rsp_data;
  end

  assign instr     = instr_mem[read_ptr[AW-1:0]];
  assign instr_pc  = pc_mem[read_ptr[AW-1:0]];
  assign instr_pc4 = instr_pc + XLEN'(4);

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised, decoupled instruction-fetch front end that replaces the single-register PC path of the single-cycle core.
- Owns the fetch PC and issues word requests to instruction memory over a valid/ready channel.
- Buffers in-order responses in a DEPTH-entry queue and presents {instr, pc, pc+4} to decode over a valid/ready channel.
- Handles branch/JAL/JALR redirects, including dropping responses that are still in flight.

Parameters:
- XLEN, 32, width of PC, addresses and instruction data.
- DEPTH, 4, queue entries and maximum requests outstanding plus buffered (power of 2, ≥2).
- RESET_PC, 32'h0000_0000, fetch PC after reset.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  output  1  fetch request valid.
- req_ready  input  1  imem accepts the request.
- req_addr  output  XLEN  word-aligned fetch address (bits [1:0] always 0).
- rsp_valid  input  1  imem response valid; in order, ≥1 cycle after the accepting handshake.
- rsp_data  input  XLEN  instruction word.
- instr_valid  output  1  decode-side entry valid.
- instr_ready  input  1  decode accepts the entry.
- instr  output  XLEN  instruction word.
- instr_pc  output  XLEN  address of instr.
- instr_pc4  output  XLEN  instr_pc + 4, modulo 2^XLEN.
- redirect_valid  input  1  take a new PC (branch taken, JAL, JALR).
- redirect_pc  input  XLEN  target address.
- misaligned  output  1  one-cycle registered pulse: previous-cycle redirect had redirect_pc[1]=1.

Behaviour:
- Reset (reset=0, asynchronous):
  - fetch_pc = RESET_PC.
  - alloc, fill and read pointers = 0; drop_cnt = 0.
  - misaligned = 0; req_valid = 0; instr_valid = 0.
- Queue structure:
  - An entry is allocated at each request handshake and its PC is written then.
  - The entry's instr is written when its response arrives.
  - Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
  - occupancy = alloc - read (0..DEPTH). Entries between read and fill are filled.
- Request issue:
  - req_valid = (occupancy < DEPTH) && !redirect_valid.
  - req_addr = fetch_pc.
  - On handshake: fetch_pc += 4 (wraps at 2^XLEN) and alloc++.
  - req_valid may drop while not yet accepted only because of redirect or reset.
- Responses:
  - If drop_cnt > 0, the response is discarded and drop_cnt--.
  - Otherwise instr is written to the fill entry and fill++.
  - A response with no outstanding request is a protocol violation; ignore it, with no state change.
- Decode output:
  - instr_valid = (read != fill) && !redirect_valid.
  - instr, instr_pc and instr_pc4 come from the read entry; they hold stable while instr_valid && !instr_ready.
  - On handshake: read++.
- Latency: an imem response arriving in cycle N appears on instr_valid in cycle N+1. There is no combinational path from rsp_* to instr_*.
- Throughput: with a 1-cycle imem and a queue that is not full, one instruction per cycle.
- Redirect (redirect_valid=1 in cycle N) has priority over every other event in that cycle:
  - No request handshake and no decode handshake occur in cycle N.
  - Next state:
    - fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}.
    - read = fill = alloc = 0.
    - drop_cnt = drop_cnt + (alloc - fill) - (rsp_valid ? 1 : 0). A response arriving in cycle N is discarded.
  - misaligned = redirect_pc[1] in cycle N+1. redirect_pc[0] is ignored (JALR semantics).
  - First request to the new target is issued in cycle N+1.
  - Back-to-back redirects: the last one wins, and drop_cnt accumulates correctly.
- Full condition:
  - occupancy == DEPTH holds req_valid low.
  - It releases in the cycle after a decode handshake frees an entry.
- Empty condition: instr_valid = 0; the block keeps requesting when imem is ready.
- Reset mid-operation: all state returns to reset values immediately. Responses to pre-reset requests arriving after reset are a protocol violation per the rule above; imem is reset by the same signal.

Test Plan:
- Reset release, imem 1-cycle latency, instr_ready=1:
  - req_addr sequence 0x0, 0x4, 0x8, 0xC.
  - instr_pc follows 2 cycles behind each address; instr_pc4 = 0x4, 0x8, …
  - One instr per cycle.
- instr_ready=0 with DEPTH=4:
  - Exactly 4 requests accepted (0x0–0xC), then req_valid=0 and instr holds the 0x0 word.
  - Raising instr_ready for 1 cycle releases exactly one more request, to 0x10.
- imem latency 3 cycles, 3 requests in flight, redirect_pc=0x100:
  - The 3 late responses are discarded.
  - First instr_valid has instr_pc=0x100.
  - drop_cnt returns to 0.
- redirect_pc=0x202 in the same cycle as rsp_valid and instr_ready:
  - Response dropped; no decode handshake.
  - misaligned=1 for one cycle.
  - Next req_addr = 0x200.
- Redirects on two consecutive cycles, 0x40 then 0x80:
  - No request to 0x40.
  - Fetch resumes at 0x80.
  - No stale instruction reaches decode.
- Wrap-around:
  - RESET_PC=32'hFFFF_FFF8 yields req_addr 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
  - instr_pc4 of 0xFFFF_FFFC = 0x0.
  - Assert reset mid-stream: req_valid=0 and instr_valid=0 immediately, without waiting for a clock edge.
